// File: rtl/i2s_stream_tx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2s_stream_tx_pkg                                                     |
// | Shared frame definition for the LED-panel serial stream (tx and rx).  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package i2s_stream_tx_pkg;

  localparam int HDR_BITS     = 16;
  localparam int NIB_BITS     = 4;

  localparam int HDR_NX_MSB   = 15;
  localparam int HDR_NX_LSB   = 12;
  localparam int HDR_NY_MSB   = 11;
  localparam int HDR_NY_LSB   = 8;
  localparam int HDR_RSVD_MSB = 7;
  localparam int HDR_RSVD_LSB = 6;
  localparam int HDR_ROW_MSB  = 5;
  localparam int HDR_ROW_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } tx_state_e;

  function automatic logic [HDR_BITS-1:0] build_header(
    input logic [3:0] nx,
    input logic [3:0] ny,
    input logic [5:0] row
  );
    logic [HDR_BITS-1:0] h;
    h = '0;
    h[HDR_NX_MSB:HDR_NX_LSB]     = nx;
    h[HDR_NY_MSB:HDR_NY_LSB]     = ny;
    h[HDR_RSVD_MSB:HDR_RSVD_LSB] = 2'b00;
    h[HDR_ROW_MSB:HDR_ROW_LSB]   = row;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_nibble_ser.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2s_nibble_ser                                                        |
// | Loadable nibble shifter; exposes the bit that follows the one on the  |
// | line plus a flag for the nibble's last bit. Rev 1.0                   |
// +-----------------------------------------------------------------------+
module i2s_nibble_ser
  import i2s_stream_tx_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
  input  logic [NIB_BITS-1:0] load_data,
  output logic                next_bit,
  output logic                last_bit
);

  logic [NIB_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]          idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load) begin
      shreg_d = load_data;
      idx_d   = 2'd0;
    end else if (shift) begin
      shreg_d = {shreg_q[NIB_BITS-2:0], 1'b0};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= 2'd0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  // shreg_q[MSB] is already on the line, so the follower is one position down
  assign next_bit = shreg_q[NIB_BITS-2];
  assign last_bit = (idx_q == 2'(NIB_BITS-1));

endmodule
`default_nettype wire

// File: rtl/i2s_stream_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2s_stream_tx                                                         |
// | LED-panel frame transmitter: 16-bit header, nibble payload, idle gap. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module i2s_stream_tx
  import i2s_stream_tx_pkg::*;
#(
  parameter int GAP_BITS = 4
) (
  input  logic       i2s_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] num_x,
  input  logic [3:0] num_y,
  input  logic [5:0] row_sel,
  input  logic [3:0] nib_data,
  input  logic       nib_valid,
  output logic       nib_ready,
  output logic       i2s_data,
  output logic       i2s_bit_en,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [3:0] HDR_LAST = 4'(HDR_BITS - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  tx_state_e           state_q, state_d;
  logic [HDR_BITS-1:0] hdr_q, hdr_d;
  logic [3:0]          hdr_cnt_q, hdr_cnt_d;
  logic [3:0]          nx_q, nx_d;
  logic [3:0]          ny_q, ny_d;
  logic [3:0]          col_q, col_d;
  logic [5:0]          line_q, line_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic                data_q, data_d;
  logic                bit_en_q, bit_en_d;

  logic [HDR_BITS-1:0] hdr_word;
  logic                ser_load, ser_shift, ser_next_bit, ser_last;
  logic                last_nib, fetch;

  assign hdr_word = build_header(num_x, num_y, row_sel);

  // col/line index the nibble currently being shifted out
  assign last_nib  = (col_q == nx_q) && (line_q == {ny_q, 2'b11});
  assign fetch     = ((state_q == ST_HEADER)  && (hdr_cnt_q == HDR_LAST)) ||
                     ((state_q == ST_PAYLOAD) && ser_last && !last_nib);
  assign ser_load  = fetch && nib_valid;
  assign ser_shift = (state_q == ST_PAYLOAD) && !ser_last;

  i2s_nibble_ser u_ser (
    .clk       (i2s_clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_data (nib_data),
    .next_bit  (ser_next_bit),
    .last_bit  (ser_last)
  );

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    hdr_cnt_d = hdr_cnt_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    col_d     = col_q;
    line_d    = line_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    bit_en_d  = bit_en_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hdr_d     = hdr_word;
          hdr_cnt_d = 4'd0;
          nx_d      = num_x;
          ny_d      = num_y;
          data_d    = hdr_word[HDR_BITS-1];
          bit_en_d  = 1'b1;
          state_d   = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (hdr_cnt_q != HDR_LAST) begin
          hdr_d     = hdr_q << 1;
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          data_d    = hdr_d[HDR_BITS-1];
          bit_en_d  = 1'b1;
        end else if (nib_valid) begin
          data_d   = nib_data[NIB_BITS-1];
          bit_en_d = 1'b1;
          col_d    = 4'd0;
          line_d   = 6'd0;
          state_d  = ST_PAYLOAD;
        end else begin
          bit_en_d = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (!ser_last) begin
          data_d   = ser_next_bit;
          bit_en_d = 1'b1;
        end else if (last_nib) begin
          data_d    = 1'b0;
          bit_en_d  = 1'b0;
          gap_cnt_d = 4'd0;
          state_d   = ST_GAP;
        end else if (nib_valid) begin
          data_d   = nib_data[NIB_BITS-1];
          bit_en_d = 1'b1;
          if (col_q == nx_q) begin
            col_d  = 4'd0;
            line_d = line_q + 6'd1;
          end else begin
            col_d  = col_q + 4'd1;
          end
        end else begin
          // underflow: the line holds its last bit with the clock gated
          bit_en_d = 1'b0;
        end
      end
      ST_GAP: begin
        data_d   = 1'b0;
        bit_en_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hdr_q     <= '0;
      hdr_cnt_q <= 4'd0;
      nx_q      <= 4'd0;
      ny_q      <= 4'd0;
      col_q     <= 4'd0;
      line_q    <= 6'd0;
      gap_cnt_q <= 4'd0;
      data_q    <= 1'b0;
      bit_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      hdr_cnt_q <= hdr_cnt_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      col_q     <= col_d;
      line_q    <= line_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      bit_en_q  <= bit_en_d;
    end
  end

  assign nib_ready  = fetch;
  assign i2s_data   = data_q;
  assign i2s_bit_en = bit_en_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);

endmodule
`default_nettype wire

// File: tb/tb_i2s_stream_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_i2s_stream_tx                                                      |
// | Directed bench with a bit-stream model of each frame. Rev 1.0         |
// +-----------------------------------------------------------------------+
module tb_i2s_stream_tx;

  localparam int GAP = 4;

  logic       i2s_clk   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic [3:0] num_x     = 4'd0;
  logic [3:0] num_y     = 4'd0;
  logic [5:0] row_sel   = 6'd0;
  logic [3:0] nib_data  = 4'd0;
  logic       nib_valid = 1'b0;
  logic       nib_ready, i2s_data, i2s_bit_en, busy, frame_done;

  i2s_stream_tx #(.GAP_BITS(GAP)) dut (
    .i2s_clk    (i2s_clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_x      (num_x),
    .num_y      (num_y),
    .row_sel    (row_sel),
    .nib_data   (nib_data),
    .nib_valid  (nib_valid),
    .nib_ready  (nib_ready),
    .i2s_data   (i2s_data),
    .i2s_bit_en (i2s_bit_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 i2s_clk = ~i2s_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- nibble source ----------------
  logic [3:0] src [0:2047];
  int  src_n     = 0;
  int  src_idx   = 0;
  int  stall_at  = -1;
  int  stall_rem = 0;
  bit  src_on    = 1'b0;

  // ready is a pure state decode, so the value at negedge is what the next posedge sees
  always @(negedge i2s_clk) begin
    if (!src_on || src_idx >= src_n) begin
      nib_valid = 1'b0;
      nib_data  = 4'h0;
    end else if (src_idx == stall_at && stall_rem > 0) begin
      nib_valid = 1'b0;
      nib_data  = 4'hF;
      if (nib_ready) stall_rem--;
    end else begin
      nib_valid = 1'b1;
      nib_data  = src[src_idx];
      if (nib_ready) src_idx++;
    end
  end

  // ---------------- frame model and compare ----------------
  bit exp_q [$];
  bit rx_bits [$];
  int frame_len [$];
  bit chk_en = 1'b0;
  int busy_cyc, en_cyc, stall_cyc, gap_cyc, done_cnt, done_at, fbits;
  int low_run, max_low_run;
  bit last_data;

  task automatic clear_model();
    exp_q.delete(); rx_bits.delete(); frame_len.delete();
    busy_cyc = 0; en_cyc = 0; stall_cyc = 0; gap_cyc = 0;
    done_cnt = 0; done_at = 0; fbits = 0; low_run = 0; max_low_run = 0;
    last_data = 1'b0;
  endtask

  task automatic add_frame(input logic [3:0] nx, input logic [3:0] ny,
                           input logic [5:0] row, input int base);
    logic [15:0] hw;
    int n;
    hw = {nx, ny, 2'b00, row};
    n  = 4 * (int'(nx) + 1) * (int'(ny) + 1);
    for (int b = 15; b >= 0; b--) exp_q.push_back(hw[b]);
    for (int k = 0; k < n; k++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(src[base + k][b]);
    frame_len.push_back(16 + 4 * n);
  endtask

  always @(negedge i2s_clk) begin
    bit eb;
    if (chk_en && rst_n) begin
      if (busy) busy_cyc++;
      if (i2s_bit_en) begin
        en_cyc++;
        if (low_run > max_low_run) max_low_run = low_run;
        low_run = 0;
        rx_bits.push_back(i2s_data);
        fbits++;
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else begin
          eb = exp_q.pop_front();
          check("stream_bit", int'(i2s_data), int'(eb));
        end
      end else begin
        if (en_cyc > 0) low_run++;
        if (busy && frame_len.size() > 0 && fbits > 0 && fbits < frame_len[0]) begin
          stall_cyc++;
          check("stall_hold", int'(i2s_data), int'(last_data));
        end else if (busy) begin
          gap_cyc++;
          check("gap_data", int'(i2s_data), 0);
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_at = busy_cyc;
        check("done_gap_cycles", gap_cyc, GAP * done_cnt);
        if (frame_len.size() == 0) check("done_without_frame", 1, 0);
        else begin
          check("frame_bits", fbits, frame_len[0]);
          void'(frame_len.pop_front());
        end
        fbits = 0;
      end
      if (!busy) begin
        check("idle_ready", int'(nib_ready), 0);
        check("idle_done", int'(frame_done), 0);
      end
      last_data = i2s_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_frame(input logic [3:0] nx, input logic [3:0] ny,
                           input logic [5:0] row, input int s_at, input int s_len);
    int  p, budget;
    bit  ended;
    p      = 16 * (int'(nx) + 1) * (int'(ny) + 1);
    budget = 16 + p + GAP + s_len + 20;
    ended  = 1'b0;
    stall_at = s_at; stall_rem = s_len; src_idx = 0; src_on = 1'b1;
    @(negedge i2s_clk);
    start = 1'b1; num_x = nx; num_y = ny; row_sel = row;
    @(negedge i2s_clk);
    // header fields must have been captured at the start edge
    start = 1'b0; num_x = ~nx; num_y = ~ny; row_sel = ~row;
    for (int c = 0; c < budget; c++) begin
      @(negedge i2s_clk); #1;
      if (!busy) begin ended = 1'b1; break; end
    end
    if (!ended) check("frame_timeout", 0, 1);
    check("busy_cycles", busy_cyc, 16 + p + GAP + s_len);
    check("bit_en_cycles", en_cyc, 16 + p);
    check("stall_cycles", stall_cyc, s_len);
    check("done_count", done_cnt, 1);
    check("done_at", done_at, 16 + p + GAP + s_len);
    check("nibbles_taken", src_idx, p / 4);
    check("model_drained", exp_q.size(), 0);
  endtask

  function automatic logic [3:0] pat(input int line, input int col);
    return 4'((line * 5 + col * 3) ^ 9);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] pin;
    logic [3:0]  nib;
    bit          ended, second;
    int          idle_between;

    rst_n = 1'b0;
    repeat (3) @(negedge i2s_clk);
    #1;
    check("rst_data", int'(i2s_data), 0);
    check("rst_bit_en", int'(i2s_bit_en), 0);
    check("rst_ready", int'(nib_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    @(negedge i2s_clk); rst_n = 1'b1;
    @(negedge i2s_clk); #1;
    chk_en = 1'b1;

    // 1: single module, A5C3
    clear_model();
    src[0] = 4'hA; src[1] = 4'h5; src[2] = 4'hC; src[3] = 4'h3; src_n = 4;
    add_frame(4'd0, 4'd0, 6'd5, 0);
    for (int i = 0; i < 32; i++) pin[31-i] = exp_q[i];
    check("model_t1_stream", int'(pin), int'(32'h0005_A5C3));
    run_frame(4'd0, 4'd0, 6'd5, -1, 0);

    // 2: 4x2 modules, nibble k decodes to line k/4, col k%4
    clear_model();
    for (int k = 0; k < 32; k++) src[k] = pat(k / 4, k % 4);
    src_n = 32;
    add_frame(4'd3, 4'd1, 6'h2A, 0);
    for (int i = 0; i < 16; i++) pin[15-i] = exp_q[i];
    check("model_t2_header", int'(pin[15:0]), int'(16'h312A));
    run_frame(4'd3, 4'd1, 6'h2A, -1, 0);
    check("t2_rx_len", rx_bits.size(), 16 + 128);
    if (rx_bits.size() == 144) begin
      for (int k = 0; k < 32; k++) begin
        for (int b = 0; b < 4; b++) nib[3-b] = rx_bits[16 + 4*k + b];
        check($sformatf("decode_mod%0d_%0d_line%0d_col%0d", k % 4, (k / 4) / 4, k / 4, k % 4),
              int'(nib), int'(pat(k / 4, k % 4)));
      end
    end

    // 3: five-cycle underflow before nibble 2
    clear_model();
    src[0] = 4'hA; src[1] = 4'h5; src[2] = 4'hC; src[3] = 4'h3; src_n = 4;
    add_frame(4'd0, 4'd0, 6'd5, 0);
    run_frame(4'd0, 4'd0, 6'd5, 2, 5);
    check("t3_low_run", max_low_run, 5);

    // 4: start held high across two frames; row changes after the first start edge
    clear_model();
    src[0] = 4'hA; src[1] = 4'h5; src[2] = 4'hC; src[3] = 4'h3;
    src[4] = 4'h1; src[5] = 4'h2; src[6] = 4'h3; src[7] = 4'h4; src_n = 8;
    add_frame(4'd0, 4'd0, 6'd5, 0);
    add_frame(4'd0, 4'd0, 6'd9, 4);
    src_idx = 0; stall_at = -1; stall_rem = 0; src_on = 1'b1;
    ended = 1'b0; second = 1'b0; idle_between = 0;
    @(negedge i2s_clk); start = 1'b1; num_x = 4'd0; num_y = 4'd0; row_sel = 6'd5;
    @(negedge i2s_clk); row_sel = 6'd9;
    for (int c = 0; c < 200; c++) begin
      @(negedge i2s_clk); #1;
      if (done_cnt == 1 && !busy) idle_between++;
      if (done_cnt == 1 && busy && idle_between > 0 && !second) begin
        second = 1'b1; start = 1'b0;
      end
      if (done_cnt == 2 && !busy) begin ended = 1'b1; break; end
    end
    start = 1'b0;
    check("t4_finished", int'(ended), 1);
    check("t4_done_count", done_cnt, 2);
    check("t4_idle_between", idle_between, 1);
    check("t4_gap_run", max_low_run, GAP + 1);
    check("t4_busy_cycles", busy_cyc, 2 * (32 + GAP));
    check("t4_bit_en_cycles", en_cyc, 64);
    check("t4_nibbles", src_idx, 8);
    check("t4_drained", exp_q.size(), 0);

    // 5: async reset in the middle of the payload
    @(negedge i2s_clk); #1;
    clear_model();
    for (int k = 0; k < 8; k++) src[k] = 4'(k + 6);
    src_n = 8;
    add_frame(4'd1, 4'd0, 6'd3, 0);
    src_idx = 0; stall_at = -1; stall_rem = 0; src_on = 1'b1;
    @(negedge i2s_clk); start = 1'b1; num_x = 4'd1; num_y = 4'd0; row_sel = 6'd3;
    @(negedge i2s_clk); start = 1'b0;
    repeat (24) @(negedge i2s_clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_data", int'(i2s_data), 0);
    check("t5_rst_bit_en", int'(i2s_bit_en), 0);
    check("t5_rst_ready", int'(nib_ready), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_done", int'(frame_done), 0);
    chk_en = 1'b0; src_on = 1'b0;
    repeat (2) @(negedge i2s_clk);
    rst_n = 1'b1;
    @(negedge i2s_clk); #1;
    clear_model();
    chk_en = 1'b1;
    for (int k = 0; k < 8; k++) src[k] = 4'(15 - 2 * k);
    src_n = 8;
    add_frame(4'd1, 4'd0, 6'd3, 0);
    run_frame(4'd1, 4'd0, 6'd3, -1, 0);

    // 6: largest frame, 1024 nibbles
    @(negedge i2s_clk); #1;
    clear_model();
    for (int k = 0; k < 1024; k++) src[k] = 4'(k ^ (k >> 4) ^ (k >> 8));
    src_n = 1024;
    add_frame(4'd15, 4'd15, 6'h3F, 0);
    run_frame(4'd15, 4'd15, 6'h3F, -1, 0);
    check("t6_done_cycle", done_at, 16 + 4096 + GAP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
